// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock sequencer: FSM state encoding,
// its width, and the default values of every sequencer parameter.
package pll_seq_pkg;

  localparam int STATE_W    = 3;
  localparam int LOSS_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int NUM_DOMAINS_DEF      = 5;
  localparam int RST_HOLD_CYC_DEF     = 16;
  localparam int LOCK_STABLE_CYC_DEF  = 1024;
  localparam int LOCK_TIMEOUT_CYC_DEF = 1000000;
  localparam int STAGGER_CYC_DEF      = 8;
  localparam int MAX_RETRY_DEF        = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and its system.
// The slave modport is the sequencer side, the master modport the system side.
interface pll_lock_sequencer_if
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = NUM_DOMAINS_DEF
);

  // restart is a one-cycle request that is always accepted on the next edge
  // (no back-pressure); ready/fail are level status, valid whenever sampled.
  logic                   restart;
  logic                   pll_locked;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst_n;
  logic                   ready;
  logic                   fail;
  logic [STATE_W-1:0]     state;
  logic [LOSS_CNT_W-1:0]  lock_loss_cnt;

  modport master (
    output restart, pll_locked,
    input  pll_rst, domain_rst_n, ready, fail, state, lock_loss_cnt
  );

  modport slave (
    input  restart, pll_locked,
    output pll_rst, domain_rst_n, ready, fail, state, lock_loss_cnt
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the local clock
// domain; both flops clear on synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for stable lock with
// timeout and retry, then releases domain resets in a staggered order.
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN builds the lock-loss counter.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS      = NUM_DOMAINS_DEF,
  parameter int RST_HOLD_CYC     = RST_HOLD_CYC_DEF,
  parameter int LOCK_STABLE_CYC  = LOCK_STABLE_CYC_DEF,
  parameter int LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
  parameter int STAGGER_CYC      = STAGGER_CYC_DEF,
  parameter int MAX_RETRY        = MAX_RETRY_DEF
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  pll_lock_sequencer_if.slave  bus
);

  // One stage counter is shared by RESET_PLL hold, WAIT_LOCK stability and
  // RELEASE stagger, so it is sized for the largest of the three.
  localparam int STAGE_W = $clog2(max3(RST_HOLD_CYC, LOCK_STABLE_CYC, STAGGER_CYC) + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [NUM_DOMAINS-1:0] DOM_FIRST = NUM_DOMAINS'(1);

  state_t                 state_q;
  logic                   pll_rst_q;
  logic                   ready_q;
  logic                   fail_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic [STAGE_W-1:0]     stage_cnt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [RETRY_W-1:0]     retry_cnt;
  logic [RETRY_W-1:0]     retry_inc;
  logic                   lock_s;

  sync_2ff u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (lock_s)
  );

  assign retry_inc = retry_cnt + RETRY_W'(1);

  always_ff @(posedge refclk) begin
    if (!rst_n || bus.restart) begin
      state_q   <= RESET_PLL;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      stage_cnt <= '0;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (stage_cnt == STAGE_W'(RST_HOLD_CYC - 1)) begin
            state_q   <= WAIT_LOCK;
            pll_rst_q <= 1'b0;
            stage_cnt <= '0;
          end else begin
            stage_cnt <= stage_cnt + STAGE_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (lock_s && stage_cnt == STAGE_W'(LOCK_STABLE_CYC - 1)) begin
            state_q   <= RELEASE;
            dom_q     <= DOM_FIRST;
            stage_cnt <= '0;
            tmo_cnt   <= '0;
          end else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT_CYC - 1)) begin
            // Timeout runs regardless of lock glitches; each expiry is one retry.
            retry_cnt <= retry_inc;
            pll_rst_q <= 1'b1;
            stage_cnt <= '0;
            tmo_cnt   <= '0;
            if (retry_inc == RETRY_W'(MAX_RETRY)) begin
              state_q <= FAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q <= RESET_PLL;
            end
          end else begin
            stage_cnt <= lock_s ? stage_cnt + STAGE_W'(1) : '0;
            tmo_cnt   <= tmo_cnt + TMO_W'(1);
          end
        end

        RELEASE: begin
          if (!lock_s) begin
            state_q   <= RESET_PLL;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            stage_cnt <= '0;
          end else if (dom_q[NUM_DOMAINS-1]) begin
            state_q   <= RUN;
            ready_q   <= 1'b1;
            retry_cnt <= '0;
          end else if (stage_cnt == STAGE_W'(STAGGER_CYC - 1)) begin
            // Domains come out of reset in index order, so a shift-in suffices.
            dom_q     <= (dom_q << 1) | DOM_FIRST;
            stage_cnt <= '0;
          end else begin
            stage_cnt <= stage_cnt + STAGE_W'(1);
          end
        end

        RUN: begin
          if (!lock_s) begin
            state_q   <= RESET_PLL;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
            stage_cnt <= '0;
          end
        end

        FAIL: begin
          pll_rst_q <= 1'b1;
          dom_q     <= '0;
          ready_q   <= 1'b0;
          fail_q    <= 1'b1;
        end

        default: begin
          state_q   <= RESET_PLL;
          pll_rst_q <= 1'b1;
          dom_q     <= '0;
          ready_q   <= 1'b0;
          fail_q    <= 1'b0;
          stage_cnt <= '0;
          tmo_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic                  loss_event;
  logic [LOSS_CNT_W-1:0] loss_cnt_q;

  // restart outranks a simultaneous lock loss, so it suppresses the count.
  assign loss_event = !bus.restart && !lock_s &&
                      (state_q == RELEASE || state_q == RUN);

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
    end else if (loss_event && loss_cnt_q != {LOSS_CNT_W{1'b1}}) begin
      loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
    end
  end

  assign bus.lock_loss_cnt = loss_cnt_q;
`else
  assign bus.lock_loss_cnt = '0;
`endif

  assign bus.pll_rst      = pll_rst_q;
  assign bus.domain_rst_n = dom_q;
  assign bus.ready        = ready_q;
  assign bus.fail         = fail_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: table-driven lock scenarios, hand-written
// corner sequences and random stimulus against a time-based reference model.
module tb_pll_lock_sequencer;

  localparam int N = 5;
  localparam int H = 4;
  localparam int L = 8;
  localparam int T = 64;
  localparam int S = 2;
  localparam int R = 3;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_REL  = 2;
  localparam int P_RUN  = 3;
  localparam int P_FAIL = 4;

`ifdef PLL_SEQ_LOSS_CNT_EN
  localparam int LOSS_ONE = 1;
`else
  localparam int LOSS_ONE = 0;
`endif

  // clock / reset
  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  always #10 refclk = ~refclk;

  pll_lock_sequencer_if #(.NUM_DOMAINS(N)) bus ();

  pll_lock_sequencer #(
    .NUM_DOMAINS      (N),
    .RST_HOLD_CYC     (H),
    .LOCK_STABLE_CYC  (L),
    .LOCK_TIMEOUT_CYC (T),
    .STAGGER_CYC      (S),
    .MAX_RETRY        (R)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: phase + cycles spent in it, lock seen through a 2-deep delay
  int m_phase = P_RST;
  int m_age   = 0;
  int m_retry = 0;
  int m_loss  = 0;
  bit sq[$];
  bit win[$];

  always @(posedge refclk) begin : model
    bit ls;
    bit stable;
    int nxt;
    if (!rst_n) begin
      m_phase = P_RST; m_age = 0; m_retry = 0; m_loss = 0;
      sq = '{1'b0, 1'b0};
      win.delete();
    end else begin
      ls = sq[0];
      void'(sq.pop_front());
      sq.push_back(bus.pll_locked);
      nxt = m_phase;
      if (bus.restart) begin
        nxt = P_RST;
        m_retry = 0;
      end else begin
        case (m_phase)
          P_RST:  if (m_age == H - 1) nxt = P_WAIT;
          P_WAIT: begin
            win.push_back(ls);
            stable = 1'b0;
            if (win.size() >= L) begin
              stable = 1'b1;
              for (int k = 0; k < L; k++) if (!win[win.size() - 1 - k]) stable = 1'b0;
            end
            if (stable) nxt = P_REL;
            else if (m_age == T - 1) begin
              m_retry++;
              nxt = (m_retry == R) ? P_FAIL : P_RST;
            end
          end
          P_REL, P_RUN: begin
            if (!ls) begin
              nxt = P_RST;
              if (m_loss < 255) m_loss++;
            end else if (m_phase == P_REL && m_age == (N - 1) * S) begin
              nxt = P_RUN;
              m_retry = 0;
            end
          end
          default: ;
        endcase
      end
      if (nxt != m_phase || bus.restart) begin
        m_phase = nxt; m_age = 0; win.delete();
      end else begin
        m_age++;
      end
    end
  end

  function automatic logic [N-1:0] exp_dom(input int ph, input int age);
    logic [N-1:0] d;
    d = '0;
    if (ph == P_RUN) d = '1;
    else if (ph == P_REL) for (int k = 0; k < N; k++) if (k * S <= age) d[k] = 1'b1;
    return d;
  endfunction

  function automatic int exp_loss();
`ifdef PLL_SEQ_LOSS_CNT_EN
    return m_loss;
`else
    return 0;
`endif
  endfunction

  always @(negedge refclk) begin
    if (chk_en) begin
      check("m_state", bus.state, m_phase);
      check("m_pll_rst", bus.pll_rst, (m_phase == P_RST || m_phase == P_FAIL));
      check("m_dom", bus.domain_rst_n, exp_dom(m_phase, m_age));
      check("m_ready", bus.ready, m_phase == P_RUN);
      check("m_fail", bus.fail, m_phase == P_FAIL);
      check("m_loss", bus.lock_loss_cnt, exp_loss());
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.restart = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (bus.state !== target && n < budget) begin
      step(1);
      n++;
    end
    check(name, bus.state, target);
  endtask

  typedef struct {
    string        name;
    int           mode;
    int           cycles;
    logic [2:0]   st;
    logic         rdy;
    logic         fl;
    logic         prst;
    logic [N-1:0] dom;
  } vec_t;

  vec_t vecs[3];
  logic [N-1:0] exp_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int prst_hi, falls, last_chg, n, hold;
    logic prev;
    logic [N-1:0] last_dom;

    vecs[0] = '{"steady_lock", 0, 40,  3'd3, 1'b1, 1'b0, 1'b0, 5'b11111};
    vecs[1] = '{"toggle_lock", 1, 70,  3'd0, 1'b0, 1'b0, 1'b1, 5'b00000};
    vecs[2] = '{"never_lock",  2, 250, 3'd4, 1'b0, 1'b1, 1'b1, 5'b00000};

    bus.restart = 1'b0;
    bus.pll_locked = 1'b0;
    rst_n = 1'b0;
    step(1);
    chk_en = 1'b1;
    check("reset_state", bus.state, 0);
    check("reset_pll_rst", bus.pll_rst, 1);
    check("reset_dom", bus.domain_rst_n, 0);

    // table-driven lock scenarios
    for (int v = 0; v < 3; v++) begin
      do_reset();
      prst_hi = 0; falls = 0; prev = 1'b1; last_chg = -1; last_dom = '0;
      exp_q.delete();
      for (int k = 0; k < N; k++) exp_q.push_back(N'((1 << (k + 1)) - 1));
      for (int c = 0; c < vecs[v].cycles; c++) begin
        case (vecs[v].mode)
          0: bus.pll_locked = 1'b1;
          1: bus.pll_locked = ((c / 5) % 2 == 0);
          default: bus.pll_locked = 1'b0;
        endcase
        if (bus.pll_rst) prst_hi++;
        if (prev && !bus.pll_rst) falls++;
        prev = bus.pll_rst;
        if (v == 0 && bus.domain_rst_n !== last_dom) begin
          if (exp_q.size() > 0) check("dom_seq", bus.domain_rst_n, exp_q.pop_front());
          else check("dom_seq_extra", bus.domain_rst_n, last_dom);
          if (last_chg >= 0) check("dom_gap", c - last_chg, S);
          last_chg = c;
          last_dom = bus.domain_rst_n;
        end
        step(1);
      end
      check({vecs[v].name, "_state"}, bus.state, vecs[v].st);
      check({vecs[v].name, "_ready"}, bus.ready, vecs[v].rdy);
      check({vecs[v].name, "_fail"}, bus.fail, vecs[v].fl);
      check({vecs[v].name, "_pll_rst"}, bus.pll_rst, vecs[v].prst);
      check({vecs[v].name, "_dom"}, bus.domain_rst_n, vecs[v].dom);
      if (v == 0) begin
        check("rst_hold_cycles", prst_hi, H);
        check("dom_seq_done", exp_q.size(), 0);
      end
      if (v == 2) check("pll_rst_pulses", falls, R);
    end

    // restart out of FAIL
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    check("restart_fail_clr", bus.fail, 0);
    check("restart_state", bus.state, P_RST);
    check("restart_pll_rst", bus.pll_rst, 1);
    step(H);
    check("restart_pulse_end", bus.pll_rst, 0);
    check("restart_wait", bus.state, P_WAIT);

    // lock drop in RUN, then relock
    do_reset();
    bus.pll_locked = 1'b1;
    wait_state("run_reached", P_RUN, 60);
    bus.pll_locked = 1'b0;
    n = 0;
    while (bus.domain_rst_n !== '0 && n < 10) begin
      step(1);
      n++;
    end
    check("drop_latency", n, 3);
    check("drop_ready", bus.ready, 0);
    check("drop_state", bus.state, P_RST);
    check("drop_loss", bus.lock_loss_cnt, LOSS_ONE);
    bus.pll_locked = 1'b1;
    wait_state("relock_run", P_RUN, 60);
    check("relock_dom", bus.domain_rst_n, 5'b11111);
    check("relock_ready", bus.ready, 1);

    // restart coincident with the synced lock drop
    bus.pll_locked = 1'b0;
    step(2);
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    check("coinc_state", bus.state, P_RST);
    check("coinc_loss", bus.lock_loss_cnt, LOSS_ONE);
    check("coinc_dom", bus.domain_rst_n, 0);

    // reset mid-RELEASE
    bus.pll_locked = 1'b1;
    wait_state("rel_reached", P_REL, 60);
    rst_n = 1'b0;
    step(1);
    check("midrst_state", bus.state, P_RST);
    check("midrst_pll_rst", bus.pll_rst, 1);
    check("midrst_dom", bus.domain_rst_n, 0);
    check("midrst_ready", bus.ready, 0);
    check("midrst_fail", bus.fail, 0);
    check("midrst_loss", bus.lock_loss_cnt, 0);
    rst_n = 1'b1;

    // random lock/restart/reset stimulus, checked by the model every cycle
    do_reset();
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        bus.pll_locked = ~bus.pll_locked;
        if (bus.pll_locked) hold = $urandom_range(5, 40);
        else if ($urandom_range(0, 7) == 0) hold = $urandom_range(80, 150);
        else hold = $urandom_range(1, 12);
      end
      hold--;
      bus.restart = ($urandom_range(0, 63) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      step(1);
    end
    bus.restart = 1'b0;
    rst_n = 1'b1;
    step(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_DOMAINS, 5: number of PLL output clock domains to sequence.
- RST_HOLD_CYC, 16: pll_rst pulse width in refclk cycles.
- LOCK_STABLE_CYC, 1024: consecutive synced-lock cycles required.
- LOCK_TIMEOUT_CYC, 1000000: lock wait limit, 20 ms at 50 MHz.
- STAGGER_CYC, 8: cycles between successive domain reset releases.
- MAX_RETRY, 3: consecutive failed lock attempts before FAIL.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- refclk, in, 1: the only clock; free-running 50 MHz reference.
- rst_n, in, 1: reset; synchronous, active-low.
- restart, in, 1: single-cycle soft restart request.
- pll_locked, in, 1: PLL locked output; asynchronous to refclk.
- pll_rst, out, 1: reset to the PLL; active-high.
- domain_rst_n, out, NUM_DOMAINS: per-domain resets; active-low, refclk domain.
- ready, out, 1: all domains released and running.
- fail, out, 1: retry limit exhausted.
- state, out, 3: current FSM state encoding.
- lock_loss_cnt, out, 8: saturating count of lock losses after release.

Function
REQ-003 pll_locked SHALL pass through a 2-flop synchronizer before use, giving 2 cycles of input latency.
REQ-004 The FSM SHALL have the states RESET_PLL=0, WAIT_LOCK=1, RELEASE=2, RUN=3 and FAIL=4.
REQ-005 RESET_PLL SHALL drive pll_rst=1 and all domain_rst_n=0 for exactly RST_HOLD_CYC cycles, then go to WAIT_LOCK.
REQ-006 WAIT_LOCK SHALL drive pll_rst=0.
REQ-007 WAIT_LOCK SHALL count consecutive synced-lock-high cycles; a low cycle SHALL clear the count, and reaching LOCK_STABLE_CYC SHALL go to RELEASE.
REQ-008 WAIT_LOCK SHALL run a timeout counter that is not cleared by lock glitches.
REQ-009 On timeout expiry, WAIT_LOCK SHALL increment the retry count and go to RESET_PLL, or to FAIL if the retry count then equals MAX_RETRY.
REQ-010 RELEASE SHALL deassert domain_rst_n[0] on its first cycle and domain_rst_n[i] STAGGER_CYC cycles after domain_rst_n[i-1].
REQ-011 RELEASE SHALL go to RUN one cycle after the last domain is released; released bits SHALL stay high.
REQ-012 RUN SHALL drive ready=1 and clear the retry count on entry.
REQ-013 A synced lock low in RELEASE or RUN SHALL, on the next edge, drive all domain_rst_n=0 and ready=0, increment lock_loss_cnt (saturating at 255), and go to RESET_PLL.
REQ-014 FAIL SHALL hold pll_rst=1, all domain_rst_n=0, ready=0 and fail=1 until restart or reset.
REQ-015 restart=1 in any state SHALL go to RESET_PLL on the next edge with the retry count and all stage counters cleared.
REQ-016 restart SHALL NOT clear lock_loss_cnt.
REQ-017 If restart and lock loss occur in the same cycle, restart SHALL take priority and lock_loss_cnt SHALL NOT increment.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 While rst_n=0, the block SHALL hold: state=RESET_PLL, pll_rst=1, domain_rst_n=all 0, ready=0, fail=0, lock_loss_cnt=0, all counters 0, synchronizer flops 0.
REQ-020 After rst_n rises, the block SHALL start a full RST_HOLD_CYC pulse.
REQ-021 Reset mid-operation SHALL abort any state immediately at the next edge.

Configuration
REQ-022 With PLL_SEQ_LOSS_CNT_EN defined, lock_loss_cnt SHALL behave per REQ-013 and REQ-016.
REQ-023 Without PLL_SEQ_LOSS_CNT_EN, lock_loss_cnt SHALL be a constant 0 and no counter register SHALL be built; all other behaviour SHALL be unchanged.

Structure
REQ-024 The package pll_seq_pkg SHALL hold the state enum, its 3-bit width constant and the parameter default values.
REQ-025 The synchronizer SHALL be the sub-module sync_2ff; all other logic SHALL reside in pll_lock_sequencer.

Verification (bench parameters: RST_HOLD_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=64, STAGGER_CYC=2, MAX_RETRY=3)
REQ-026 Lock high steady from t=0 -> pll_rst high for 4 cycles; domain_rst_n goes 00001, 00011, ... 11111 at 2-cycle spacing; ready=1; state=3.
REQ-027 Lock toggles every 5 cycles -> state stays in WAIT_LOCK; after 64 cycles retry=1 and pll_rst pulses again.
REQ-028 Lock never asserts -> exactly 3 pll_rst pulses, then fail=1 and state=4; a restart pulse gives a new pll_rst pulse and fail=0.
REQ-029 Lock drops in RUN -> within 3 cycles of the drop (2 sync + 1), domain_rst_n=00000, ready=0 and lock_loss_cnt=1; relock gives a full sequence again.
REQ-030 Restart coincident with a lock drop -> state=RESET_PLL and lock_loss_cnt unchanged; rst_n=0 mid-RELEASE -> reset values of REQ-019 next cycle.
REQ-031 Build without PLL_SEQ_LOSS_CNT_EN and repeat REQ-029 -> lock_loss_cnt=0; all other outputs identical.
